// File: rtl/axi_slave_mem.sv
// AXI4 slave memory model with FIXED/INCR/WRAP bursts, independent read and write engines and per-beat SLVERR.
// Define AXI_SLAVE_MEM_WSTRB_EN to honour wstrb byte lanes; otherwise every good beat writes the full word.
module axi_slave_mem #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int LEN_W  = 8
) (
    input  logic                aclk,
    input  logic                areset_n,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [LEN_W-1:0]    awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [LEN_W-1:0]    arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
);
    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // Handshake rule on every channel: a transfer happens on the rising edge where valid and ready are both 1;
    // every ready/valid driven here depends on FSM state alone, never combinationally on an input.
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic [ADDR_W-1:0] beat_idx(input logic [ADDR_W-1:0] idx, input logic [LEN_W-1:0] len,
                                                   input logic [1:0] burst, input logic [LEN_W-1:0] beat);
        logic [ADDR_W-1:0] lenx;
        logic [ADDR_W-1:0] beatx;
        lenx  = ADDR_W'(len);
        beatx = ADDR_W'(beat);
        case (burst)
            2'b00:   beat_idx = idx;
            2'b10:   beat_idx = (idx & ~lenx) | ((idx + beatx) & lenx);
            default: beat_idx = idx + beatx;
        endcase
    endfunction

    function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst, input logic [LEN_W-1:0] len);
        logic wrap_ok;
        wrap_ok   = (len == LEN_W'(1)) || (len == LEN_W'(3)) || (len == LEN_W'(7)) || (len == LEN_W'(15));
        burst_err = (size != 3'(OFF_W)) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_ok);
    endfunction

    // ---------------- read engine ----------------
    r_state_t          r_state, r_state_n;
    logic [ADDR_W-1:0] r_idx;
    logic [LEN_W-1:0]  r_len, r_beat;
    logic [1:0]        r_burst;
    logic              r_berr;
    logic              ld_en, ld_err, r_done;
    logic [ADDR_W-1:0] ld_idx;

    always_comb begin
        r_state_n = r_state;
        ld_en     = 1'b0;
        ld_err    = 1'b0;
        ld_idx    = '0;
        r_done    = 1'b0;
        arready   = (r_state == R_IDLE);
        rvalid    = (r_state == R_DATA);
        rlast     = (r_state == R_DATA) && (r_beat == r_len);
        case (r_state)
            R_IDLE: if (arvalid) begin
                r_state_n = R_DATA;
                ld_en     = 1'b1;
                ld_idx    = araddr >> OFF_W;
                ld_err    = burst_err(arsize, arburst, arlen);
            end
            R_DATA: if (rready) begin
                if (r_beat == r_len) begin
                    r_state_n = R_IDLE;
                    r_done    = 1'b1;
                end else begin
                    ld_en  = 1'b1;
                    ld_idx = beat_idx(r_idx, r_len, r_burst, r_beat + 1'b1);
                    ld_err = r_berr;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
        ld_err = ld_err || (ld_idx >= ADDR_W'(DEPTH));
    end

    // rdata is registered when a beat is presented, so a same-edge write is seen only by later beats.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            r_state <= R_IDLE;
            r_idx   <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_burst <= 2'b00;
            r_berr  <= 1'b0;
            rdata   <= '0;
            rresp   <= OKAY;
        end else begin
            r_state <= r_state_n;
            if (arready && arvalid) begin
                r_idx   <= araddr >> OFF_W;
                r_len   <= arlen;
                r_burst <= arburst;
                r_berr  <= burst_err(arsize, arburst, arlen);
                r_beat  <= '0;
            end else if (rvalid && rready) begin
                r_beat <= r_beat + 1'b1;
            end
            if (ld_en) begin
                rdata <= ld_err ? '0 : mem[ld_idx[IDX_W-1:0]];
                rresp <= ld_err ? SLVERR : OKAY;
            end else if (r_done) begin
                rdata <= '0;
                rresp <= OKAY;
            end
        end
    end

    // ---------------- write engine ----------------
    w_state_t          w_state, w_state_n;
    logic [ADDR_W-1:0] w_idx, w_cur;
    logic [LEN_W-1:0]  w_len, w_beat;
    logic [1:0]        w_burst;
    logic              w_berr, w_err, w_beat_err;

    always_comb begin
        w_state_n  = w_state;
        awready    = (w_state == W_IDLE);
        wready     = (w_state == W_DATA);
        bvalid     = (w_state == W_RESP);
        bresp      = w_err ? SLVERR : OKAY;
        w_cur      = beat_idx(w_idx, w_len, w_burst, w_beat);
        w_beat_err = w_berr || (w_cur >= ADDR_W'(DEPTH)) || (wlast != (w_beat == w_len));
        case (w_state)
            W_IDLE:  if (awvalid) w_state_n = W_DATA;
            W_DATA:  if (wvalid && (w_beat == w_len)) w_state_n = W_RESP;
            W_RESP:  if (bready) w_state_n = W_IDLE;
            default: w_state_n = W_IDLE;
        endcase
    end

`ifndef AXI_SLAVE_MEM_WSTRB_EN
    logic unused_wstrb;
    assign unused_wstrb = ^wstrb;
`endif

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            w_state <= W_IDLE;
            w_idx   <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_burst <= 2'b00;
            w_berr  <= 1'b0;
            w_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            w_state <= w_state_n;
            if (awready && awvalid) begin
                w_idx   <= awaddr >> OFF_W;
                w_len   <= awlen;
                w_burst <= awburst;
                w_berr  <= burst_err(awsize, awburst, awlen);
                w_beat  <= '0;
                w_err   <= 1'b0;
            end else if (wready && wvalid) begin
                w_beat <= (w_beat == w_len) ? '0 : w_beat + 1'b1;
                w_err  <= w_err | w_beat_err;
                if (!w_beat_err) begin
`ifdef AXI_SLAVE_MEM_WSTRB_EN
                    for (int b = 0; b < DATA_W / 8; b++)
                        if (wstrb[b]) mem[w_cur[IDX_W-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
`else
                    mem[w_cur[IDX_W-1:0]] <= wdata;
`endif
                end
            end
        end
    end
endmodule
